// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings and default bit timing.
// Used by the transmitter and by the byte sequencer that drives it.
package uart_pkg;

    localparam int CLKS_PER_BIT_DEFAULT = 434;

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        START = 4'd1,
        DATA  = 4'd2,
        STOP  = 4'd3,
        HOLD  = 4'd9
    } uart_state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Baud timer: bit_end pulses for one cycle every CLKS_PER_BIT cycles.
// A clear restarts the count so the next pulse lands a full bit period later.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_end
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    // Wrapping on the terminal count itself keeps every bit exactly CLKS_PER_BIT long.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign bit_end = (cnt == LAST) && !clear;

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a level send / done handshake toward the sequencer.
// txd and uart_send_done are registered; reset forces the line idle without a clock.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_send,
    input  logic [7:0] send_data,
    output logic       txd,
    output logic       uart_send_done,
    output logic [3:0] uart_send_sta
);

    uart_state_t state;
    logic [7:0]  shreg;
    logic [2:0]  idx;
    logic        bit_end;
    logic        accept;

    assign accept = (state == IDLE) && uart_send;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .rst    (rst),
        .clear  (accept),
        .bit_end(bit_end)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            shreg          <= '0;
            idx            <= '0;
            txd            <= 1'b1;
            uart_send_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    txd            <= 1'b1;
                    uart_send_done <= 1'b0;
                    if (uart_send) begin
                        shreg <= send_data;
                        idx   <= '0;
                        txd   <= 1'b0;
                        state <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        txd   <= shreg[0];
                        idx   <= '0;
                        state <= DATA;
                    end
                end
                DATA: begin
                    // shreg[0] is the bit on the line; shifting exposes the next one.
                    if (bit_end) begin
                        if (idx == 3'd7) begin
                            txd   <= 1'b1;
                            state <= STOP;
                        end else begin
                            txd   <= shreg[1];
                            shreg <= shreg >> 1;
                            idx   <= idx + 3'd1;
                        end
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        txd            <= 1'b1;
                        uart_send_done <= 1'b1;
                        state          <= HOLD;
                    end
                end
                HOLD: begin
                    txd <= 1'b1;
                    if (!uart_send) begin
                        uart_send_done <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: begin
                    txd            <= 1'b1;
                    uart_send_done <= 1'b0;
                    state          <= IDLE;
                end
            endcase
        end
    end

    assign uart_send_sta = state;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at CLKS_PER_BIT=4; inputs driven and outputs sampled on negedge.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       uart_send = 1'b0;
    logic [7:0] send_data = 8'h00;
    logic       txd;
    logic       uart_send_done;
    logic [3:0] uart_send_sta;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    uart_tx #(
        .CLKS_PER_BIT(4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .uart_send     (uart_send),
        .send_data     (send_data),
        .txd           (txd),
        .uart_send_done(uart_send_done),
        .uart_send_sta (uart_send_sta)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the line idle. Sample k is the k-th negedge after the
    // accepting edge, so done must first appear at k=41 (cycle N+1+40).
    task automatic send_check(input logic [7:0] b, input logic [7:0] late, input string tag);
        logic [9:0] frame;
        int         busy;
        int         exp_sta;
        frame     = {1'b1, b, 1'b0};
        busy      = 0;
        send_data = b;
        uart_send = 1'b1;
        for (int k = 1; k <= 41; k++) begin
            @(negedge clk);
            if (k == 1) send_data = late;
            if (k <= 40) begin
                exp_sta = (k <= 4) ? 1 : ((k <= 36) ? 2 : 3);
                check({tag, " txd"}, txd, frame[(k-1)/4]);
                check({tag, " sta"}, uart_send_sta, exp_sta);
                check({tag, " done_low"}, uart_send_done, 0);
                if (uart_send_sta != 4'd0 && uart_send_sta != 4'd9) busy++;
            end else begin
                check({tag, " done_rise"}, uart_send_done, 1);
                check({tag, " sta_hold"}, uart_send_sta, 9);
                check({tag, " txd_hold"}, txd, 1);
            end
        end
        check({tag, " width"}, busy, 40);
    endtask

    task automatic drop_send(input string tag);
        uart_send = 1'b0;
        @(negedge clk);
        check({tag, " sta_idle"}, uart_send_sta, 0);
        check({tag, " done_clr"}, uart_send_done, 0);
        check({tag, " txd_idle"}, txd, 1);
    endtask

    initial begin
        int  seen_done;
        int  w;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst txd", txd, 1);
        check("rst done", uart_send_done, 0);
        check("rst sta", uart_send_sta, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle txd", txd, 1);
        check("idle sta", uart_send_sta, 0);

        // 0xA5 frame, then uart_send held through HOLD
        send_check(8'hA5, 8'hA5, "a5");
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("hold txd", txd, 1);
            check("hold sta", uart_send_sta, 9);
        end
        drop_send("a5");
        @(negedge clk);
        check("no_resend sta", uart_send_sta, 0);

        // Data changed after acceptance must not leak into the frame
        send_check(8'h3C, 8'hFF, "late");
        drop_send("late");

        // Extreme patterns: frame width and stop bit
        send_check(8'hFF, 8'hFF, "ff");
        drop_send("ff");
        send_check(8'h00, 8'h00, "zero");
        drop_send("zero");

        // Reset during DATA bit 3 of 0x00 (samples 17..20)
        send_data = 8'h00;
        uart_send = 1'b1;
        repeat (18) @(negedge clk);
        check("mid sta_data", uart_send_sta, 2);
        check("mid txd_low", txd, 0);
        rst = 1'b1;
        uart_send = 1'b0;
        #1;
        check("mid txd_async", txd, 1);
        check("mid sta_async", uart_send_sta, 0);
        check("mid done_async", uart_send_done, 0);
        @(negedge clk);
        rst = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (uart_send_done) seen_done = 1;
        end
        check("mid no_done", seen_done, 0);
        check("mid sta_after", uart_send_sta, 0);
        check("mid txd_after", txd, 1);

        // Request pending across reset release is taken at the first edge
        rst = 1'b1;
        uart_send = 1'b1;
        send_data = 8'h5A;
        @(negedge clk);
        check("pend rst_sta", uart_send_sta, 0);
        rst = 1'b0;
        @(negedge clk);
        check("pend sta_start", uart_send_sta, 1);
        check("pend txd_start", txd, 0);
        w = 0;
        while (!uart_send_done && w < 60) begin
            @(negedge clk);
            w++;
        end
        check("pend timeout", (w >= 60), 0);
        drop_send("pend");

        // 40 back-to-back bytes through the sequencer handshake and a line monitor
        fork
            begin : sequencer
                for (int i = 0; i < 40; i++) begin
                    int ws;
                    send_data = 8'(i);
                    uart_send = 1'b1;
                    ws = 0;
                    @(negedge clk);
                    while (!uart_send_done && ws < 100) begin
                        @(negedge clk);
                        ws++;
                    end
                    check("seq timeout", (ws >= 100), 0);
                    if (ws >= 100) break;
                    uart_send = 1'b0;
                    @(negedge clk);
                end
                uart_send = 1'b0;
            end
            begin : monitor
                for (int f = 0; f < 40; f++) begin
                    logic [7:0] rx;
                    int         wm;
                    wm = 0;
                    while (txd !== 1'b0 && wm < 200) begin
                        @(negedge clk);
                        wm++;
                    end
                    check("mon timeout", (wm >= 200), 0);
                    if (wm >= 200) break;
                    @(negedge clk);
                    check("mon start", txd, 0);
                    for (int b = 0; b < 8; b++) begin
                        repeat (4) @(negedge clk);
                        rx[b] = txd;
                    end
                    repeat (4) @(negedge clk);
                    check("mon stop", txd, 1);
                    check("mon byte", rx, f);
                end
            end
        join
        repeat (4) @(negedge clk);
        check("b2b sta_idle", uart_send_sta, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 434, meaning clk cycles per serial bit (50 MHz / 115200 baud); legal range 2..65535.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port uart_send, input, 1 bit: level send request from the byte sequencer, held until uart_send_done is seen.
REQ-005 The block SHALL have port send_data, input, 8 bits: the byte to transmit, valid while uart_send=1.
REQ-006 The block SHALL have port txd, output, 1 bit: the serial line; idle high.
REQ-007 The block SHALL have port uart_send_done, output, 1 bit: a level that is high only in state HOLD.
REQ-008 The block SHALL have port uart_send_sta, output, 4 bits: the current state encoding.

Function
REQ-009 The state encodings SHALL be IDLE=0, START=1, DATA=2, STOP=3, HOLD=9; other codes are unreachable and SHALL return to IDLE on the next edge.
REQ-010 In IDLE, txd SHALL be 1; if uart_send=1 at an edge, send_data SHALL be latched into an 8-bit shift register, the baud counter cleared, and the state set to START.
REQ-011 In START, txd SHALL be 0 for exactly CLKS_PER_BIT cycles, then the state SHALL become DATA with bit index 0.
REQ-012 In DATA, txd SHALL present latched bits LSB first, each for exactly CLKS_PER_BIT cycles; a 3-bit index SHALL count 0..7, and after bit 7 the state SHALL become STOP.
REQ-013 In STOP, txd SHALL be 1 for exactly CLKS_PER_BIT cycles, then the state SHALL become HOLD.
REQ-014 In HOLD, txd SHALL be 1 and uart_send_done SHALL be 1; the state SHALL return to IDLE on the first edge where uart_send=0.
REQ-015 A byte accepted at edge N SHALL drive START on txd from cycle N+1; uart_send_done SHALL rise at cycle N+1+10*CLKS_PER_BIT.
REQ-016 Changes on send_data or uart_send after acceptance and before HOLD SHALL be ignored.
REQ-017 uart_send held high through HOLD SHALL NOT cause a second transmission; a new byte requires uart_send low for at least one edge.
REQ-018 The baud counter SHALL be wide enough for CLKS_PER_BIT-1 and SHALL wrap to 0 at each bit boundary without losing cycles.
REQ-019 txd SHALL be driven from a register, with no combinational glitches.

Reset
REQ-020 While rst=1, the state SHALL be IDLE, txd=1, uart_send_done=0, uart_send_sta=0, and the counter, index, and shift register SHALL be 0.
REQ-021 Reset asserted mid-frame SHALL force txd=1 immediately, without waiting for a clock; the frame is abandoned and no uart_send_done is produced.
REQ-022 After rst deasserts, a pending uart_send=1 SHALL be accepted at the first following edge.

Structure
REQ-023 The state encodings (IDLE, START, DATA, STOP, HOLD) and the default CLKS_PER_BIT SHALL live in a shared package uart_pkg, also used by the sequencer.
REQ-024 The baud timing SHALL be one sub-module, uart_baud_gen, with inputs clk, rst, clear and output bit_end, where bit_end is a 1-cycle pulse every CLKS_PER_BIT cycles.
REQ-025 The remaining logic SHALL be one registered state machine; there SHALL be no latches and no combinational feedback to uart_send.

Verification (CLKS_PER_BIT=4)
REQ-026 Send 0xA5 -> txd SHALL be 0,1,0,1,0,0,1,0,1,1 for 4 cycles each, starting 1 cycle after acceptance; uart_send_sta SHALL go 1,2,3,9; uart_send_done SHALL rise 41 cycles after acceptance.
REQ-027 Hold uart_send=1 through HOLD for 20 cycles -> txd SHALL stay 1 and state 9; dropping uart_send SHALL give state 0 on the next edge.
REQ-028 Send 40 back-to-back bytes 0x00..0x27 with the sequencer handshake -> a UART monitor SHALL decode all 40 in order with no framing errors.
REQ-029 Assert rst for 1 cycle during DATA bit 3 of 0x00 -> txd SHALL be 1 within the same cycle; uart_send_done SHALL stay 0; the state SHALL be 0.
REQ-030 Change send_data from 0x3C to 0xFF one cycle after acceptance -> the decoded byte SHALL be 0x3C.
REQ-031 Send 0xFF and then 0x00 -> each frame SHALL be exactly 40 cycles wide, with the stop bit high.
